// File: rtl/gauss_line_buffer_if.sv
// Pixel-in / column-out signal bundle for the Gaussian line buffer.
// master: pixel source; slave: line buffer.
interface gauss_line_buffer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_in;
  logic [DATA_W-1:0] row1_out;
  logic [DATA_W-1:0] row2_out;
  logic [DATA_W-1:0] row3_out;
  logic              out_valid;
  logic              out_sol;
  logic              out_eol;
  logic              frame_done;
  logic              resync_err;

  modport master (
    output pix_valid, pix_sof, pix_in,
    input  row1_out, row2_out, row3_out, out_valid, out_sol, out_eol, frame_done, resync_err
  );

  modport slave (
    input  pix_valid, pix_sof, pix_in,
    output row1_out, row2_out, row3_out, out_valid, out_sol, out_eol, frame_done, resync_err
  );
endinterface

// File: rtl/gauss_line_buffer.sv
// Two-line buffer presenting one 3-sample vertical column per accepted pixel.
// Optional top-border replication enabled by defining LB_TOP_REPLICATE_EN.
module gauss_line_buffer #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned DATA_W     = 8
) (
  input logic                 clk,
  input logic                 reset,
  gauss_line_buffer_if.slave  bus
);
  localparam int unsigned ColW  = $clog2(IMG_WIDTH);
  localparam int unsigned LineW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0]  ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e             state_q, state_d;
  logic [ColW-1:0]    col_q, col_d, cur_col;
  logic [LineW-1:0]   line_q, line_d, cur_line;
  logic [DATA_W-1:0]  row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;
  logic               valid_q, valid_d, sol_q, sol_d, eol_q, eol_d;
  logic               done_q, done_d, resync_q, resync_d;
  logic               restart, accept, last_col, emit;
  logic [DATA_W-1:0]  rd_a, rd_b;

  logic [DATA_W-1:0]  lb_a [IMG_WIDTH];
  logic [DATA_W-1:0]  lb_b [IMG_WIDTH];

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    line_d   = line_q;
    row1_d   = row1_q;
    row2_d   = row2_q;
    row3_d   = row3_q;
    valid_d  = 1'b0;
    sol_d    = 1'b0;
    eol_d    = 1'b0;
    done_d   = 1'b0;
    emit     = 1'b0;
    restart  = bus.pix_valid && bus.pix_sof;
    accept   = bus.pix_valid && (restart || state_q != StIdle);
    resync_d = restart && state_q != StIdle;
    // A sof pixel is always line 0 col 0, regardless of where the counters were.
    cur_col  = restart ? '0 : col_q;
    cur_line = restart ? '0 : line_q;
    last_col = cur_col == ColLast;
    rd_a     = lb_a[cur_col];
    rd_b     = lb_b[cur_col];

    if (accept) begin
      row3_d = bus.pix_in;
`ifdef LB_TOP_REPLICATE_EN
      if (cur_line == '0) begin
        row1_d = bus.pix_in;
        row2_d = bus.pix_in;
      end else if (cur_line == LineW'(1)) begin
        row1_d = rd_a;
        row2_d = rd_a;
      end else begin
        row1_d = rd_b;
        row2_d = rd_a;
      end
      emit = !resync_d;
`else
      row1_d = rd_b;
      row2_d = rd_a;
      emit   = (state_q == StStream) && !restart;
`endif
      valid_d = emit;
      sol_d   = emit && (cur_col == '0);
      eol_d   = emit && last_col;

      if (last_col) begin
        col_d  = '0;
        line_d = (cur_line == LineLast) ? '0 : cur_line + LineW'(1);
      end else begin
        col_d  = cur_col + ColW'(1);
        line_d = cur_line;
      end

      if (restart) begin
        state_d = StFill;
      end else if (state_q == StFill && last_col && cur_line == LineW'(1)) begin
        state_d = StStream;
      end else if (state_q == StStream && last_col && cur_line == LineLast) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      col_q    <= '0;
      line_q   <= '0;
      row1_q   <= '0;
      row2_q   <= '0;
      row3_q   <= '0;
      valid_q  <= 1'b0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      done_q   <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      row1_q   <= row1_d;
      row2_q   <= row2_d;
      row3_q   <= row3_d;
      valid_q  <= valid_d;
      sol_q    <= sol_d;
      eol_q    <= eol_d;
      done_q   <= done_d;
      resync_q <= resync_d;
    end
  end

  // Read-before-write: lb_a shifts down into lb_b as the new pixel lands in lb_a.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      lb_b[cur_col] <= rd_a;
      lb_a[cur_col] <= bus.pix_in;
    end
  end

  assign bus.row1_out   = row1_q;
  assign bus.row2_out   = row2_q;
  assign bus.row3_out   = row3_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_sol    = sol_q;
  assign bus.out_eol    = eol_q;
  assign bus.frame_done = done_q;
  assign bus.resync_err = resync_q;
endmodule

// File: tb/tb_gauss_line_buffer.sv
// Self-checking bench for gauss_line_buffer on a 4x4 image.
// Honours LB_TOP_REPLICATE_EN when defined for the build.
module tb_gauss_line_buffer;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gauss_line_buffer_if #(.DATA_W(DW)) bus ();

  gauss_line_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int vo_cnt   = 0;
  bit chk_en   = 1'b0;

  // Frame-level reference model: image array plus pixel index within frame.
  logic [7:0] img [H][W];
  bit         in_frame   = 1'b0;
  int         n          = 0;
  bit         rows_known = 1'b0;
  logic       exp_valid, exp_sol, exp_eol, exp_done, exp_resync;
  logic [7:0] exp_r1, exp_r2, exp_r3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clk(input bit v, input bit s, input logic [7:0] d, input bit r);
    int l, c;
    bit out;
    exp_valid = 0; exp_sol = 0; exp_eol = 0; exp_done = 0; exp_resync = 0;
    if (r) begin
      in_frame = 0; n = 0;
      exp_r1 = '0; exp_r2 = '0; exp_r3 = '0;
      rows_known = 1;
      return;
    end
    if (v && s) begin
      exp_resync = in_frame;
      in_frame   = 1;
      n          = 0;
    end else if (v && in_frame) begin
      n = n + 1;
    end
    if (v && in_frame) begin
      l = n / W;
      c = n % W;
      img[l][c] = d;
      out = 0;
`ifdef LB_TOP_REPLICATE_EN
      if (!exp_resync) begin
        out = 1;
        if (l == 0) begin
          exp_r1 = d; exp_r2 = d;
        end else if (l == 1) begin
          exp_r1 = img[0][c]; exp_r2 = img[0][c];
        end else begin
          exp_r1 = img[l-2][c]; exp_r2 = img[l-1][c];
        end
        exp_r3 = d;
      end
`else
      if (l >= 2) begin
        out = 1;
        exp_r1 = img[l-2][c]; exp_r2 = img[l-1][c]; exp_r3 = d;
      end
`endif
      rows_known = out;
      exp_valid  = out;
      exp_sol    = out && (c == 0);
      exp_eol    = out && (c == W - 1);
      if (n == W * H - 1) begin
        in_frame = 0;
        exp_done = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", bus.out_valid, exp_valid);
      chk("out_sol", bus.out_sol, exp_sol);
      chk("out_eol", bus.out_eol, exp_eol);
      chk("frame_done", bus.frame_done, exp_done);
      chk("resync_err", bus.resync_err, exp_resync);
      if (rows_known) begin
        chk("row1_out", bus.row1_out, exp_r1);
        chk("row2_out", bus.row2_out, exp_r2);
        chk("row3_out", bus.row3_out, exp_r3);
      end
      if (bus.out_valid === 1'b1) vo_cnt++;
    end
  end

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit r);
    reset = r; bus.pix_valid = v; bus.pix_sof = s; bus.pix_in = d;
    @(posedge clk);
    model_clk(v, s, d, r);
    @(negedge clk);
    reset = 1'b0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
  endtask

  task automatic lit_rows(input string name, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] r3, input bit sol, input bit eol);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_row1"}, bus.row1_out, r1);
    chk({name, "_row2"}, bus.row2_out, r2);
    chk({name, "_row3"}, bus.row3_out, r3);
    chk({name, "_sol"}, bus.out_sol, sol);
    chk({name, "_eol"}, bus.out_eol, eol);
  endtask

  task automatic frame_run(input logic [7:0] base, input bit gap, input int first,
                           input int stop, input bit lits);
    for (int k = first; k < stop; k++) begin
      step(1'b1, k == 0, base + 8'(16 * (k / W) + (k % W)), 1'b0);
      if (lits) begin
`ifdef LB_TOP_REPLICATE_EN
        if (k == 2) lit_rows("l0c2", 8'h02, 8'h02, 8'h02, 0, 0);
        if (k == 6) lit_rows("l1c2", 8'h02, 8'h02, 8'h12, 0, 0);
`else
        if (k == 1) chk("fill_no_valid", bus.out_valid, 0);
`endif
        if (k == 9)  lit_rows("l2c1", 8'h01, 8'h11, 8'h21, 0, 0);
        if (k == 15) begin
          lit_rows("l3c3", 8'h13, 8'h23, 8'h33, 0, 1);
          chk("frame_done_lit", bus.frame_done, 1);
        end
      end
      if (gap) begin
        step(1'b0, 1'b0, 8'h00, 1'b0);
        if (lits && k == 9) begin
          chk("gap_valid", bus.out_valid, 0);
          chk("gap_hold_row3", bus.row3_out, 8'h21);
        end
      end
    end
  endtask

  task automatic full_frame(input string name, input bit gap);
    vo_cnt = 0;
    frame_run(8'h00, gap, 0, W * H, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef LB_TOP_REPLICATE_EN
    chk({name, "_valid_count"}, vo_cnt, 16);
`else
    chk({name, "_valid_count"}, vo_cnt, 8);
`endif
  endtask

  initial begin
    reset = 1'b0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_in = '0;
    chk_en = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_rows", {bus.row1_out, bus.row2_out, bus.row3_out}, 0);

    // Continuous frame, then the same frame with a gap after every pixel.
    full_frame("cont", 1'b0);
    full_frame("gapped", 1'b1);

    // Non-sof pixels while idle are dropped.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'hAA, 1'b0);
      chk("idle_drop_valid", bus.out_valid, 0);
    end
    full_frame("after_idle", 1'b0);

    // Resync at line 2 col 2.
    frame_run(8'h00, 1'b0, 0, 10, 1'b0);
    frame_run(8'h80, 1'b0, 0, 1, 1'b0);
    chk("resync_pulse", bus.resync_err, 1);
    chk("resync_no_valid", bus.out_valid, 0);
    frame_run(8'h80, 1'b0, 1, 9, 1'b0);
    lit_rows("resync_l2c0", 8'h80, 8'h90, 8'hA0, 1, 0);
    frame_run(8'h80, 1'b0, 9, W * H, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset at line 3 col 1.
    frame_run(8'h00, 1'b0, 0, 13, 1'b0);
    step(1'b1, 1'b0, 8'h31, 1'b1);
    chk("midreset_valid", bus.out_valid, 0);
    chk("midreset_rows", {bus.row1_out, bus.row2_out, bus.row3_out}, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    full_frame("after_reset", 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gauss_line_buffer.md
Name: gauss_line_buffer

Overview:
Upstream stage of the Gaussian filter. Accepts a raster-order 8-bit pixel stream and buffers the two previous image lines in internal line memories. For each accepted pixel it presents the three vertically aligned samples of one column (two lines ago, previous line, current line). These drive the filter's In1/In2/In3 inputs, one column per cycle.

Parameters:
IMG_WIDTH, 64, pixels per line (>=4)
IMG_HEIGHT, 64, lines per frame (>=3)
DATA_W, 8, pixel width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pix_valid  in  1  pixel present on pix_in this cycle
pix_sof  in  1  first pixel of frame; qualified by pix_valid
pix_in  in  DATA_W  input pixel
row1_out  out  DATA_W  column sample from line L-2 (feeds filter In1)
row2_out  out  DATA_W  column sample from line L-1 (feeds filter In2)
row3_out  out  DATA_W  column sample from line L (feeds filter In3)
out_valid  out  1  row*_out hold a valid column
out_sol  out  1  with out_valid: column 0 of a line
out_eol  out  1  with out_valid: column IMG_WIDTH-1 of a line
frame_done  out  1  one-cycle pulse after last pixel of frame accepted
resync_err  out  1  one-cycle pulse: pix_sof received mid-frame

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. No backpressure; every accepted pixel is consumed.
- Reset: state IDLE, col=0, line=0. All outputs 0. Line memories are not cleared.
- FSM states:
  - IDLE: pix_valid&&!pix_sof dropped. pix_valid&&pix_sof accepts pixel as line 0 col 0 and enters FILL.
  - FILL: lines 0 and 1. Pixels are written to memory; out_valid=0. Enters STREAM when the last pixel of line 1 is accepted.
  - STREAM: lines 2..IMG_HEIGHT-1 produce output. On the last pixel (line IMG_HEIGHT-1, col IMG_WIDTH-1): return to IDLE, frame_done=1 next cycle.
- Counters: col increments per accepted pixel, wraps IMG_WIDTH-1 -> 0 and increments line. line never exceeds IMG_HEIGHT-1.
- Memories: lb_a holds line L-1 and lb_b holds line L-2, each IMG_WIDTH x DATA_W, addressed by col. Accepted pixel at col c, same edge, read-before-write:
  - row1_out<=lb_b[c], row2_out<=lb_a[c], row3_out<=pix_in
  - lb_b[c]<=lb_a[c], lb_a[c]<=pix_in
- Latency: exactly 1 cycle from accepted pixel to out_valid and row*_out.
- out_valid=1 only in the cycle after a pixel is accepted in STREAM (or during FILL, see Optional Feature). Idle cycles give out_valid=0 with row*_out holding their last values.
- out_sol/out_eol are registered with out_valid; they are 0 whenever out_valid=0.
- pix_sof with pix_valid in FILL/STREAM: frame restarts with this pixel as line 0 col 0; state FILL; resync_err=1 next cycle; out_valid=0 next cycle.
- pix_sof without pix_valid is ignored.
- Reset asserted mid-frame: next cycle IDLE with outputs 0. Stale memory is overwritten during FILL before use.
- Data passes unsigned, no arithmetic on pixel values.

Optional Feature:
Macro LB_TOP_REPLICATE_EN.
- Defined: top-border replication. Output is produced from line 0:
  - Line 0: row1=row2=row3=pix_in.
  - Line 1: row1=row2=lb_a[c], row3=pix_in.
  - out_valid/out_sol/out_eol assert during FILL as in STREAM.
  - Output line count per frame = IMG_HEIGHT.
- Not defined: no output during FILL; output line count per frame = IMG_HEIGHT-2.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4; frame with pixel=16*line+col, continuous valid. Without macro: 8 out_valid cycles. Line 2 col 1 gives row1=0x01, row2=0x11, row3=0x21. Line 3 col 3 gives row1=0x13, row2=0x23, row3=0x33 with out_eol=1. frame_done one cycle after pixel 0x33.
2. Same frame, pix_valid toggled 1/0 every cycle -> identical output values and order. out_valid=0 on gap cycles; row*_out held across gaps.
3. In IDLE, pix_valid=1, pix_sof=0, pix_in=0xAA for 5 cycles -> out_valid=0, no state change. A following sof frame behaves exactly as test 1.
4. pix_sof at line 2 col 2 -> resync_err pulse, out_valid=0 next cycle. Restarted frame of value 0x80+16*line+col gives line 2 col 0 row1=0x80, row2=0x90, row3=0xA0.
5. reset=1 for one cycle at line 3 col 1 -> all outputs 0 next cycle, state IDLE. Subsequent full frame matches test 1 exactly.
6. With LB_TOP_REPLICATE_EN: test 1 frame gives 16 out_valid cycles. Line 0 col 2 gives 0x02/0x02/0x02. Line 1 col 2 gives 0x02/0x02/0x12.
